// File: rtl/mc_datapath_if.sv
// Control word, status and memory bus between the multicycle
// controller (master) and the datapath (slave).
interface mc_datapath_if #(
  parameter int WIDTH = 16
);
  logic             pcwrite;
  logic             branch;
  logic             irwrite;
  logic             regwrite;
  logic             memwrite;
  logic             iord;
  logic             memtoreg;
  logic             regdst;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       pcsrc;
  logic [1:0]       aluop;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_we;
  logic [3:0]       op;
  logic             zero;

  modport master (
    output pcwrite, branch, irwrite, regwrite,
    output memwrite, iord, memtoreg, regdst,
    output alusrca, alusrcb, pcsrc, aluop,
    output mem_rdata,
    input  mem_addr, mem_wdata, mem_we, op, zero
  );

  modport slave (
    input  pcwrite, branch, irwrite, regwrite,
    input  memwrite, iord, memtoreg, regdst,
    input  alusrca, alusrcb, pcsrc, aluop,
    input  mem_rdata,
    output mem_addr, mem_wdata, mem_we, op, zero
  );
endinterface

// File: rtl/mc_datapath.sv
// Multicycle 16-bit datapath: PC, IR, MDR, A, B, ALUOut,
// 8-entry register file (R0 = 0) and a unified memory port.
module mc_datapath #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int AW    = 3
) (
  input logic         clk,
  input logic         reset,
  mc_datapath_if.slave bus
);

  logic [WIDTH-1:0] pc, ir, mdr, a, b, aluout;
  logic [WIDTH-1:0] rf [NREG];

  logic [AW-1:0]    rs, rt, rd, widx;
  logic [WIDTH-1:0] imm, srca, srcb, result;
  logic [WIDTH-1:0] pcnext, wdata, rda, rdb;
  logic             pcen;

  assign rs  = ir[11:9];
  assign rt  = ir[8:6];
  assign rd  = ir[5:3];
  assign imm = {{(WIDTH-6){ir[5]}}, ir[5:0]};

  assign rda = (rs == '0) ? '0 : rf[rs];
  assign rdb = (rt == '0) ? '0 : rf[rt];

  assign widx  = bus.regdst ? rd : rt;
  assign wdata = bus.memtoreg ? mdr : aluout;

  assign srca = bus.alusrca ? a : pc;

  // ALU B operand mux; both upper codes pick the immediate
  always_comb begin
    srcb = imm;
    case (bus.alusrcb)
      2'b00:   srcb = b;
      2'b01:   srcb = WIDTH'(1);
      default: srcb = imm;
    endcase
  end

  // ALU: add by default, subtract for compare, NAND for op 0010
  always_comb begin
    result = srca + srcb;
    if (bus.aluop == 2'b01)
      result = srca - srcb;
    else if (bus.aluop == 2'b10 && bus.op == 4'b0010)
      result = ~(srca & srcb);
  end

  // Next-PC source; codes 01 and 11 both take ALUOut
  always_comb begin
    pcnext = aluout;
    case (bus.pcsrc)
      2'b00:   pcnext = result;
      2'b10:   pcnext = a;
      default: pcnext = aluout;
    endcase
  end

  assign pcen = bus.pcwrite | (bus.branch & bus.zero);

  assign bus.zero      = (result == '0);
  assign bus.op        = ir[15:12];
  assign bus.mem_addr  = bus.iord ? aluout : pc;
  assign bus.mem_wdata = b;
  assign bus.mem_we    = bus.memwrite;

  // Architectural and non-architectural datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      ir     <= '0;
      mdr    <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
    end else begin
      if (pcen)
        pc <= pcnext;
      if (bus.irwrite)
        ir <= bus.mem_rdata;
      mdr    <= bus.mem_rdata;
      a      <= rda;
      b      <= rdb;
      aluout <= result;
    end
  end

  // Register file; writes to R0 are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (bus.regwrite && widx != '0) begin
      rf[widx] <= wdata;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed self-checking bench for mc_datapath: drives the
// control word cycle by cycle and checks hand-computed values.
module tb_mc_datapath;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mc_datapath_if #(.WIDTH(16)) bus ();

  mc_datapath #(
    .WIDTH(16),
    .NREG (8),
    .AW   (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.pcwrite  = 1'b0;
    bus.branch   = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regwrite = 1'b0;
    bus.memwrite = 1'b0;
    bus.iord     = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regdst   = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.aluop    = 2'b00;
  endtask

  task automatic load_ir(input logic [15:0] w);
    clr();
    bus.mem_rdata = w;
    bus.irwrite   = 1'b1;
    cyc();
    clr();
    cyc();
  endtask

  task automatic load_reg(input logic [2:0] idx,
                          input logic [15:0] val);
    clr();
    bus.mem_rdata = {4'h0, 3'd0, idx, 6'd0};
    bus.irwrite   = 1'b1;
    cyc();
    clr();
    bus.mem_rdata = val;
    cyc();
    bus.regwrite = 1'b1;
    bus.memtoreg = 1'b1;
    cyc();
    clr();
  endtask

  task automatic read_reg(input string tag,
                          input logic [2:0] idx,
                          input logic [15:0] exp);
    load_ir({4'h0, 3'd0, idx, 6'd0});
    chk(tag, bus.mem_wdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    clr();
    bus.mem_rdata = 16'h0000;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_pc", bus.mem_addr, 16'h0000);
    chk("rst_op", {12'h0, bus.op}, 16'h0000);
    chk("rst_wdata", bus.mem_wdata, 16'h0000);
    chk("rst_we", {15'h0, bus.mem_we}, 16'h0000);
    bus.iord = 1'b1;
    #1;
    chk("rst_aluout", bus.mem_addr, 16'h0000);

    // fetch
    clr();
    bus.mem_rdata = 16'h0A40;
    bus.pcwrite   = 1'b1;
    bus.irwrite   = 1'b1;
    bus.alusrcb   = 2'b01;
    #1;
    chk("fetch_zero", {15'h0, bus.zero}, 16'h0000);
    cyc();
    clr();
    #1;
    chk("fetch_pc", bus.mem_addr, 16'h0001);
    chk("fetch_op", {12'h0, bus.op}, 16'h0000);

    // ADD r3 = r1 + r2
    load_reg(3'd1, 16'h00F0);
    load_reg(3'd2, 16'h0F0F);
    load_ir(16'h0298);
    bus.alusrca = 1'b1;
    bus.aluop   = 2'b10;
    cyc();
    clr();
    bus.iord     = 1'b1;
    bus.regwrite = 1'b1;
    bus.regdst   = 1'b1;
    #1;
    chk("add_aluout", bus.mem_addr, 16'h0FFF);
    cyc();
    clr();
    read_reg("add_rf3", 3'd3, 16'h0FFF);

    // NAND r3 = ~(r1 & r2)
    load_ir(16'h2298);
    chk("nand_op", {12'h0, bus.op}, 16'h0002);
    bus.alusrca = 1'b1;
    bus.aluop   = 2'b10;
    cyc();
    clr();
    bus.iord     = 1'b1;
    bus.regwrite = 1'b1;
    bus.regdst   = 1'b1;
    #1;
    chk("nand_aluout", bus.mem_addr, 16'hFFFF);
    cyc();
    clr();
    read_reg("nand_rf3", 3'd3, 16'hFFFF);

    // LW r5, -2(r1)
    load_reg(3'd1, 16'h0010);
    load_ir(16'h837E);
    bus.alusrca = 1'b1;
    bus.alusrcb = 2'b10;
    cyc();
    clr();
    bus.iord = 1'b1;
    #1;
    chk("lw_addr", bus.mem_addr, 16'h000E);
    bus.mem_rdata = 16'hBEEF;
    cyc();
    clr();
    bus.regwrite = 1'b1;
    bus.memtoreg = 1'b1;
    cyc();
    clr();
    read_reg("lw_rf5", 3'd5, 16'hBEEF);

    // SW drives B and write enable
    bus.memwrite = 1'b1;
    bus.iord     = 1'b1;
    #1;
    chk("sw_we", {15'h0, bus.mem_we}, 16'h0001);
    chk("sw_wdata", bus.mem_wdata, 16'hBEEF);
    clr();

    // PC = 5 via pcsrc = A
    load_reg(3'd6, 16'h0005);
    load_ir(16'h0C00);
    bus.pcwrite = 1'b1;
    bus.pcsrc   = 2'b10;
    cyc();
    clr();
    #1;
    chk("pc_from_a", bus.mem_addr, 16'h0005);

    // BEQ not taken: r1 != r2
    load_ir(16'h4283);
    bus.alusrcb = 2'b11;
    cyc();
    clr();
    bus.iord = 1'b1;
    #1;
    chk("bne_target", bus.mem_addr, 16'h0008);
    clr();
    bus.alusrca = 1'b1;
    bus.aluop   = 2'b01;
    bus.branch  = 1'b1;
    bus.pcsrc   = 2'b01;
    #1;
    chk("bne_zero", {15'h0, bus.zero}, 16'h0000);
    cyc();
    clr();
    #1;
    chk("bne_pc", bus.mem_addr, 16'h0005);

    // BEQ taken: r1 == r1
    load_ir(16'h4243);
    bus.alusrcb = 2'b11;
    cyc();
    clr();
    bus.iord = 1'b1;
    #1;
    chk("beq_target", bus.mem_addr, 16'h0008);
    clr();
    bus.alusrca = 1'b1;
    bus.aluop   = 2'b01;
    bus.branch  = 1'b1;
    bus.pcsrc   = 2'b01;
    #1;
    chk("beq_zero", {15'h0, bus.zero}, 16'h0001);
    cyc();
    clr();
    #1;
    chk("beq_pc", bus.mem_addr, 16'h0008);

    // write to R0 is discarded
    load_reg(3'd7, 16'h1234);
    load_ir(16'h0E00);
    bus.alusrca = 1'b1;
    bus.alusrcb = 2'b10;
    cyc();
    clr();
    bus.iord = 1'b1;
    #1;
    chk("r0_aluout", bus.mem_addr, 16'h1234);
    bus.regwrite = 1'b1;
    bus.regdst   = 1'b1;
    cyc();
    clr();
    read_reg("r0_read", 3'd0, 16'h0000);

    // read-before-write on A
    load_reg(3'd4, 16'h1111);
    clr();
    bus.mem_rdata = 16'h0820;
    bus.irwrite   = 1'b1;
    cyc();
    clr();
    bus.mem_rdata = 16'h55AA;
    cyc();
    bus.regwrite = 1'b1;
    bus.memtoreg = 1'b1;
    bus.regdst   = 1'b1;
    cyc();
    clr();
    bus.alusrca = 1'b1;
    bus.iord    = 1'b1;
    cyc();
    chk("rbw_old", bus.mem_addr, 16'h1111);
    cyc();
    chk("rbw_new", bus.mem_addr, 16'h55AA);
    clr();

    // reset beats all enables
    bus.mem_rdata = 16'h3ABC;
    bus.regwrite  = 1'b1;
    bus.pcwrite   = 1'b1;
    bus.irwrite   = 1'b1;
    bus.memtoreg  = 1'b1;
    bus.regdst    = 1'b1;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    clr();
    #1;
    chk("mid_pc", bus.mem_addr, 16'h0000);
    chk("mid_op", {12'h0, bus.op}, 16'h0000);
    chk("mid_b", bus.mem_wdata, 16'h0000);
    bus.iord = 1'b1;
    #1;
    chk("mid_aluout", bus.mem_addr, 16'h0000);
    clr();
    read_reg("mid_rf4", 3'd4, 16'h0000);
    read_reg("mid_rf5", 3'd5, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
Multicycle datapath consuming the control word produced by the main decoder FSM each cycle. It also returns the current opcode and the ALU zero flag to that controller. Holds the PC, the non-architectural registers (IR, MDR, A, B, ALUOut) and an 8-entry register file, and drives a unified instruction/data memory. Uses a 16-bit ISA: op[15:12], rs[11:9], rt[8:6], rd[5:3], imm6[5:0].

Parameters:
WIDTH, 16, datapath and instruction width in bits
NREG, 8, register-file depth; R0 reads as zero
AW, 3, register index width (log2 NREG)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
pcwrite  input  1  unconditional PC load
branch  input  1  PC load qualified by zero
irwrite  input  1  IR load enable
regwrite  input  1  register-file write enable
memwrite  input  1  memory write request, passed through
iord  input  1  memory address select: 0 = PC, 1 = ALUOut
memtoreg  input  1  write-back data select: 0 = ALUOut, 1 = MDR
regdst  input  1  write-back index select: 0 = rt, 1 = rd
alusrca  input  1  ALU A select: 0 = PC, 1 = A
alusrcb  input  2  ALU B select: 00 = B, 01 = constant 1, 10 = sext(imm6), 11 = sext(imm6)
pcsrc  input  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = A, 11 = ALUOut
aluop  input  2  00 = add, 01 = subtract, 10 = per IR op, 11 = add
mem_rdata  input  WIDTH  combinational memory read data
mem_addr  output  WIDTH  memory address
mem_wdata  output  WIDTH  memory write data (= B)
mem_we  output  1  memory write enable (= memwrite)
op  output  4  IR[15:12], to controller
zero  output  1  ALU result == 0 (combinational)

Behaviour:
- All state updates on the rising edge of clk; no other edges used.
- Reset (synchronous, takes priority over all enables, may arrive in any cycle):
  - PC, IR, MDR, A, B, ALUOut all clear to 0.
  - All register-file entries clear to 0.
  - Consequences: op = 0, mem_addr = 0, mem_wdata = 0.
- PC:
  - pcen = pcwrite | (branch & zero).
  - When pcen = 1, PC loads the pcsrc-selected value.
  - When pcen = 0, PC holds.
- IR loads mem_rdata when irwrite = 1, otherwise holds.
- MDR <= mem_rdata every cycle (unconditional).
- A <= RF[rs] and B <= RF[rt] every cycle, both read combinationally from the current IR.
- ALUOut <= ALU result every cycle.
- Register file:
  - Write on regwrite; index = regdst ? rd : rt; data = memtoreg ? MDR : ALUOut.
  - A write to index 0 is discarded; reads of index 0 return 0.
- Read/write in the same cycle: A/B capture the pre-write value (read-before-write). The new value is visible from the next cycle.
- ALU operation:
  - aluop 00: add.
  - aluop 01: subtract (A−B, used for BEQ compare).
  - aluop 10 with op = 0000: add.
  - aluop 10 with op = 0010: bitwise NAND.
  - aluop 10 with op = 1101: add.
  - aluop 10 with any other op: add.
- Arithmetic is modulo 2^WIDTH. No carry or overflow outputs.
- sext(imm6) replicates bit 5 up to WIDTH.
- mem_addr = iord ? ALUOut : PC, combinational.
- Word addressing: PC+1 is the next instruction.
- PC wraps from 0xFFFF to 0x0000 with no flag.
- Latency:
  - Register-file writes are visible in A/B one cycle after the write edge.
  - The PC update is visible on mem_addr in the cycle after pcen.
- No internal FSM. Sequencing is entirely the controller's. Unknown control values must not corrupt registers whose enables are 0.

Test Plan:
- Reset then fetch: reset high 2 cycles → PC = 0. mem_rdata = 0x0A40, pcwrite = irwrite = 1, alusrca = 0, alusrcb = 01, pcsrc = 00 → next cycle PC = 1, IR = 0x0A40, op = 0000.
- ADD/NAND: RF1 = 0x00F0, RF2 = 0x0F0F. IR = op 0000, rs = 1, rt = 2, rd = 3. Run execute (alusrca = 1, alusrcb = 00, aluop = 10), then writeback (regwrite = 1, regdst = 1) → RF3 = 0x0FFF. Repeat with op 0010 → RF3 = 0xFFFF.
- LW/SW: RF1 = 0x0010, imm6 = 0x3E (−2).
  - Memadr → ALUOut = 0x000E. iord = 1 → mem_addr = 0x000E.
  - LW path: mem_rdata = 0xBEEF, memtoreg = 1, regdst = 0 → RF[rt] = 0xBEEF.
  - SW path: memwrite = 1 → mem_we = 1, mem_wdata = B.
- BEQ taken and not taken: PC = 5, imm6 = 3, decode with alusrcb = 11 → ALUOut = 8.
  - Branch state with A = B (aluop = 01, branch = 1, pcsrc = 01) → zero = 1, PC = 8.
  - Same with A ≠ B → PC stays 5.
- R0 and bypass: writeback to rd = 0 with ALUOut = 0x1234 → RF0 reads 0. Write RF4 = 0x55AA while IR.rs = 4 → A captures the old value this cycle and 0x55AA the next.
- Reset mid-operation: assert reset during a cycle with regwrite = pcwrite = irwrite = 1 → the write is suppressed and all registers are 0 at the next edge.
